// File: rtl/palette_fade_ctrl.sv
// Palette brightness fader: scales the looked-up colour by the current level
// and sequences fade-out, hold-at-black and fade-in on frame boundaries.
module palette_fade_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned HOLD_FRAMES     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       start_fade,
  input  logic       resume,
  input  logic [4:0] pix_index,
  input  logic       pix_valid,
  output logic [4:0] pal_index,
  input  logic [3:0] pal_red,
  input  logic [3:0] pal_green,
  input  logic [3:0] pal_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       out_valid,
  output logic       busy,
  output logic       at_black,
  output logic       done,
  output logic [3:0] level
);

  localparam int unsigned FW = 4;
  localparam int unsigned HW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   level_q, level_d;
  logic [FW-1:0]   frame_q, frame_d, frame_inc;
  logic [HW-1:0]   hold_q, hold_d, hold_inc;
  logic            resume_q, resume_d;
  logic            at_black_d, done_d;
  logic            step_hit, hold_ok;

  // c * (level + 1) keeps the top nibble: level 15 is identity, level 0 is black
  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [CW-1:0] lvl);
    logic [7:0] p;
    p = 8'(c) * 8'({1'b0, lvl} + 5'd1);
    return p[7:4];
  endfunction

  assign pal_index = pix_index;
  assign level     = level_q;

  // Saturating counters
  assign frame_inc = (frame_q == {FW{1'b1}}) ? frame_q : frame_q + FW'(1);
  assign hold_inc  = (hold_q == {HW{1'b1}}) ? hold_q : hold_q + HW'(1);
  assign step_hit  = (frame_inc >= FW'(FRAMES_PER_STEP));
  assign hold_ok   = (hold_inc >= HW'(HOLD_FRAMES));

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    resume_d   = resume_q;
    at_black_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        level_d  = 4'd15;
        frame_d  = '0;
        hold_d   = '0;
        resume_d = 1'b0;
        if (start_fade) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (frame_start) begin
          if (step_hit) begin
            frame_d = '0;
            level_d = level_q - 4'd1;
            if (level_q == 4'd1) begin
              state_d    = HOLD;
              at_black_d = 1'b1;
              hold_d     = '0;
              resume_d   = 1'b0;
            end
          end else begin
            frame_d = frame_inc;
          end
        end
      end
      HOLD: begin
        level_d = 4'd0;
        if (resume) resume_d = 1'b1;
        if (frame_start) begin
          hold_d = hold_inc;
          if (hold_ok && (resume_q || resume)) begin
            state_d = FADE_IN;
            frame_d = '0;
          end
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          if (step_hit) begin
            frame_d = '0;
            level_d = level_q + 4'd1;
            if (level_q == 4'd14) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            frame_d = frame_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= 4'd15;
      frame_q   <= '0;
      hold_q    <= '0;
      resume_q  <= 1'b0;
      busy      <= 1'b0;
      at_black  <= 1'b0;
      done      <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      frame_q   <= frame_d;
      hold_q    <= hold_d;
      resume_q  <= resume_d;
      busy      <= (state_d != IDLE);
      at_black  <= at_black_d;
      done      <= done_d;
      red       <= pix_valid ? scale(pal_red, level_q) : '0;
      green     <= pix_valid ? scale(pal_green, level_q) : '0;
      blue      <= pix_valid ? scale(pal_blue, level_q) : '0;
      out_valid <= pix_valid;
    end
  end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Bench for palette_fade_ctrl: random colours and control noise against a
// phase/frame-count reference model.
module tb_palette_fade_ctrl;

  localparam int FPS  = 2;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start, start_fade, resume, pix_valid;
  logic [4:0] pix_index, pal_index;
  logic [3:0] pal_red, pal_green, pal_blue;
  logic [3:0] red, green, blue, level;
  logic       out_valid, busy, at_black, done;

  int total = 0;
  int bad   = 0;

  // reference model state: phase 0 idle, 1 fading out, 2 black, 3 fading in
  int m_phase, m_lvl, m_frames, m_hold;
  bit m_resumed;
  int e_r, e_g, e_b, e_v, e_black, e_done;

  palette_fade_ctrl #(.FRAMES_PER_STEP(FPS), .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .start_fade(start_fade),
    .resume(resume), .pix_index(pix_index), .pix_valid(pix_valid), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid), .busy(busy),
    .at_black(at_black), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_lvl = 15; m_frames = 0; m_hold = 0; m_resumed = 0;
  endtask

  // Advance the model across one clock edge using the inputs of that cycle
  task automatic model_step(input bit fs, input bit sf, input bit rs);
    e_v     = pix_valid;
    e_r     = pix_valid ? (int'(pal_red)   * (m_lvl + 1)) / 16 : 0;
    e_g     = pix_valid ? (int'(pal_green) * (m_lvl + 1)) / 16 : 0;
    e_b     = pix_valid ? (int'(pal_blue)  * (m_lvl + 1)) / 16 : 0;
    e_black = 0;
    e_done  = 0;
    case (m_phase)
      0: if (sf) begin m_phase = 1; m_frames = 0; end
      1: if (fs) begin
        m_frames++;
        m_lvl = 15 - m_frames / FPS;
        if (m_lvl == 0) begin m_phase = 2; m_hold = 0; m_resumed = 0; e_black = 1; end
      end
      2: begin
        if (rs) m_resumed = 1;
        if (fs) begin
          m_hold++;
          if (m_hold >= HOLD && m_resumed) begin m_phase = 3; m_frames = 0; end
        end
      end
      default: if (fs) begin
        m_frames++;
        m_lvl = m_frames / FPS;
        if (m_lvl == 15) begin m_phase = 0; e_done = 1; end
      end
    endcase
  endtask

  task automatic cyc_px(input bit fs, input bit sf, input bit rs, input bit pv,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    frame_start = fs; start_fade = sf; resume = rs;
    pix_valid = pv; pal_red = r; pal_green = g; pal_blue = b;
    pix_index = 5'($urandom);
    #1 chk("pal_index", pal_index, pix_index);
    @(posedge clk);
    model_step(fs, sf, rs);
    #1;
    chk("red", red, e_r);
    chk("green", green, e_g);
    chk("blue", blue, e_b);
    chk("out_valid", out_valid, e_v);
    chk("level", level, m_lvl);
    chk("busy", busy, m_phase != 0);
    chk("at_black", at_black, e_black);
    chk("done", done, e_done);
  endtask

  task automatic cyc(input bit fs, input bit sf, input bit rs);
    cyc_px(fs, sf, rs, ($urandom % 4) != 0, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // n frame_starts with random gaps; optional resume pulse after frame rs_after;
  // noise adds stray start_fade/resume pulses between frames (never after the last)
  task automatic frames(input int n, input int rs_after, input bit noise);
    for (int i = 1; i <= n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == rs_after) cyc(1'b0, 1'b0, 1'b1);
      if (i < n) begin
        int gap;
        gap = int'($urandom % 3);
        for (int k = 0; k < gap; k++)
          cyc(1'b0, noise && ($urandom % 2 == 0), noise && ($urandom % 2 == 0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 0; start_fade = 0; resume = 0; pix_valid = 1;
    pix_index = '0; pal_red = 4'hF; pal_green = 4'hF; pal_blue = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 15);
    chk("rst_busy", busy, 0);
    chk("rst_red", red, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_black", at_black, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    // idle pass-through, then control noise that must not start anything but a fade
    cyc_px(0, 0, 0, 1, 4'hF, 4'hD, 4'hA);
    chk("pass_r", red, 4'hF);
    chk("pass_g", green, 4'hD);
    chk("pass_b", blue, 4'hA);
    for (int i = 0; i < 6; i++) cyc($urandom % 2 == 0, 1'b0, $urandom % 2 == 0);

    // round 1: frame_start coincident with start_fade is not counted
    cyc(1'b1, 1'b1, 1'b0);
    frames(16, 0, 1);
    cyc_px(0, 0, 0, 1, 4'hF, 4'h8, 4'h1);
    chk("scale_r", red, 7);
    chk("scale_g", green, 4);
    chk("scale_b", blue, 0);
    frames(14, 0, 1);
    chk("black_level", level, 0);
    chk("black_pulse", at_black, 1);
    frames(8, 3, 0);
    chk("fadein_busy", busy, 1);
    frames(30, 0, 1);
    chk("full_level", level, 15);
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);

    // round 2: resume withheld past the minimum hold
    cyc(1'b0, 1'b1, 1'b0);
    frames(30, 0, 1);
    frames(12, 0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    frames(1, 0, 0);
    frames(30, 0, 1);

    // round 3: resume in the hold entry cycle
    cyc(1'b0, 1'b1, 1'b0);
    frames(30, 0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    frames(8, 0, 0);
    frames(30, 0, 1);

    // round 4: asynchronous reset while holding at black
    cyc(1'b0, 1'b1, 1'b0);
    frames(30, 0, 0);
    frames(3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_level", level, 15);
    chk("abort_busy", busy, 0);
    chk("abort_red", red, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    model_reset();
    @(posedge clk);
    #1 chk("abort_done2", done, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc($urandom % 2 == 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/palette_fade_ctrl.md
PALETTE_FADE_CTRL -- requirements
Module: palette_fade_ctrl

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 2: number of frame_start pulses between brightness steps (legal 1..15).
REQ-002 Parameter HOLD_FRAMES, default 8: minimum frame_start pulses spent at black (legal 1..255).
REQ-003 Clk  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 Reset_n  in  1  reset, asynchronous assert, active-low; one clock domain only.
REQ-005 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-006 start_fade  in  1  one-cycle request to begin a fade-out/fade-in sequence.
REQ-007 resume  in  1  one-cycle pulse, room swap complete, fade-in permitted.
REQ-008 pix_index  in  5  palette index from sprite/background mux.
REQ-009 pix_valid  in  1  pix_index is valid this cycle.
REQ-010 pal_index  out  5  index to palette lookup, combinational copy of pix_index.
REQ-011 pal_red, pal_green, pal_blue  in  4 each  palette lookup result for pal_index, same cycle.
REQ-012 red, green, blue  out  4 each  faded colour, registered.
REQ-013 out_valid  out  1  registered copy of pix_valid.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 at_black  out  1  one-cycle pulse on entry to HOLD.
REQ-016 done  out  1  one-cycle pulse on return from FADE_IN to IDLE.
REQ-017 level  out  4  current brightness, 15 = full, 0 = black.

Function
REQ-018 Colour path latency SHALL be exactly 1 cycle: red/green/blue and out_valid update every cycle regardless of FSM state.
REQ-019 Each channel SHALL be computed as bits [7:4] of c * (level + 1), c 4-bit, level+1 5-bit, 8-bit product; level 15 returns c unchanged, level 0 returns 0.
REQ-020 When pix_valid is low, red/green/blue SHALL register 0.
REQ-021 FSM states SHALL be IDLE, FADE_OUT, HOLD, FADE_IN.
REQ-022 IDLE: level = 15; start_fade -> FADE_OUT, frame counter cleared; a frame_start coincident with start_fade is not counted.
REQ-023 FADE_OUT: each FRAMES_PER_STEP-th counted frame_start decrements level by 1; the decrement reaching 0 moves to HOLD.
REQ-024 HOLD: level = 0; at_black pulses in the entry cycle; resume is latched sticky; exit to FADE_IN at the first frame_start for which at least HOLD_FRAMES frame_starts have been counted in HOLD and resume is latched.
REQ-025 FADE_IN: each FRAMES_PER_STEP-th frame_start increments level by 1; the increment reaching 15 moves to IDLE and pulses done.
REQ-026 level SHALL change only in a cycle where frame_start is high (no mid-frame tearing).
REQ-027 start_fade while busy SHALL be ignored; resume outside HOLD SHALL be ignored (not latched).
REQ-028 resume coincident with the HOLD entry cycle SHALL be latched.
REQ-029 Frame and hold counters SHALL saturate, never wrap.

Reset
REQ-030 While Reset_n is low: state IDLE, level 15, counters 0, resume latch 0, red/green/blue 0, out_valid 0, busy 0, at_black 0, done 0.
REQ-031 Reset_n asserted mid-sequence SHALL abort immediately to the REQ-030 values; no done pulse is emitted.

Verification
REQ-032 Pass-through: IDLE, pix_valid=1, pal RGB = F,D,A -> next cycle red/green/blue = F,D,A, out_valid=1.
REQ-033 Scaling: level forced to 7 via fade, pal RGB = F,8,1 -> outputs 7,4,0.
REQ-034 Fade-out timing, FRAMES_PER_STEP=2: start_fade then 30 frame_starts -> level reaches 0 on the 30th, at_black pulses once, busy=1.
REQ-035 Hold gating, HOLD_FRAMES=8: resume on 3rd hold frame -> FADE_IN entered on 8th frame_start; resume withheld until after 12 frames -> FADE_IN on the next frame_start after resume.
REQ-036 Full cycle: fade-in 30 frame_starts -> level 15, done one pulse, busy 0; start_fade issued during FADE_IN -> no effect.
REQ-037 Reset_n low during HOLD -> level 15, busy 0, outputs 0 within the same cycle, no done.
